// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 valid/ready demux with manual or alternating-slot routing and saturating per-output beat counters.
module stream_demux2 #(
  parameter int WIDTH    = 8,
  parameter int AUTO_SEL = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             slot,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic             out0_valid_q, out0_valid_d, out1_valid_q, out1_valid_d;
  logic [WIDTH-1:0] out0_data_q, out0_data_d, out1_data_q, out1_data_d;
  logic             slot_q, slot_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             tgt, acc0, acc1;
  always_comb begin
    tgt          = (AUTO_SEL != 0) ? slot_q : in_sel;
    in_ready     = rst_n && (tgt ? (!out1_valid_q || out1_ready) : (!out0_valid_q || out0_ready));
    acc0         = in_valid && in_ready && !tgt;
    acc1         = in_valid && in_ready && tgt;
    out0_valid_d = acc0 || (out0_valid_q && !out0_ready);
    out1_valid_d = acc1 || (out1_valid_q && !out1_ready);
    out0_data_d  = acc0 ? in_data : out0_data_q;
    out1_data_d  = acc1 ? in_data : out1_data_q;
    cnt0_d       = (acc0 && cnt0_q != '1) ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d       = (acc1 && cnt1_q != '1) ? cnt1_q + CNT_W'(1) : cnt1_q;
    slot_d       = ((AUTO_SEL != 0) && (acc0 || acc1)) ? !slot_q : slot_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      slot_q       <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      slot_q       <= slot_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end
  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign slot       = slot_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
endmodule

// File: tb/tb_stream_demux2.sv
// tb_stream_demux2: three demux variants (manual, auto-slot, 2-bit counters) on shared stimulus, checked against a beat-level model.
module tb_stream_demux2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, iv, isel, r0, r1;
  logic [7:0] idat;
  logic       rdy[3], v0[3], v1[3], sl[3];
  logic [7:0] d0[3], d1[3], c0[3], c1[3];
  int vecs = 0, errs = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 2 : 8;
    logic [CW-1:0] a, b;
    stream_demux2 #(.WIDTH(8), .AUTO_SEL((g == 1) ? 1 : 0), .CNT_W(CW)) u (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy[g]), .in_data(idat), .in_sel(isel),
      .out0_valid(v0[g]), .out0_ready(r0), .out0_data(d0[g]),
      .out1_valid(v1[g]), .out1_ready(r1), .out1_data(d1[g]),
      .slot(sl[g]), .cnt0(a), .cnt1(b));
    assign c0[g] = 8'(a);
    assign c1[g] = 8'(b);
  end
  // model: per instance, whether each output holds a beat, which beat, the slot and the beat tallies
  bit         mv[3][2];
  logic [7:0] md[3][2];
  bit         ms[3];
  int         mc[3][2];
  function automatic int tgt_of(int k);
    return (k == 1) ? int'(ms[k]) : int'(isel);
  endfunction
  function automatic logic exp_rdy(int k);
    int t = tgt_of(k);
    return rst_n && (!mv[k][t] || ((t != 0) ? r1 : r0));
  endfunction
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      int   t   = tgt_of(k);
      int   top = (k == 2) ? 3 : 255;
      logic a   = iv && exp_rdy(k);
      if (!rst_n) begin
        mv[k] = '{0, 0}; md[k] = '{0, 0}; mc[k] = '{0, 0}; ms[k] = 0;
      end else begin
        if (r0) mv[k][0] = 0;
        if (r1) mv[k][1] = 0;
        if (a) begin
          mv[k][t] = 1;
          md[k][t] = idat;
          mc[k][t] = (mc[k][t] + 1 > top) ? top : mc[k][t] + 1;
          if (k == 1) ms[k] = !ms[k];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0; iv = 0;
    tick();
    rst_n = 1;
  endtask
  task automatic test_reset();
    rst_n = 0; iv = 1; idat = 8'hA5; isel = 0; r0 = 1; r1 = 1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      vecs += 8;
      if (rdy[k] !== 1'b0) begin errs++; $display("FAIL reset_rdy[%0d] got %b want 0", k, rdy[k]); end
      if (v0[k] !== 1'b0) begin errs++; $display("FAIL reset_v0[%0d] got %b want 0", k, v0[k]); end
      if (v1[k] !== 1'b0) begin errs++; $display("FAIL reset_v1[%0d] got %b want 0", k, v1[k]); end
      if (d0[k] !== 8'h00) begin errs++; $display("FAIL reset_d0[%0d] got %h want 00", k, d0[k]); end
      if (d1[k] !== 8'h00) begin errs++; $display("FAIL reset_d1[%0d] got %h want 00", k, d1[k]); end
      if (sl[k] !== 1'b0) begin errs++; $display("FAIL reset_slot[%0d] got %b want 0", k, sl[k]); end
      if (c0[k] !== 8'h00) begin errs++; $display("FAIL reset_cnt0[%0d] got %0d want 0", k, c0[k]); end
      if (c1[k] !== 8'h00) begin errs++; $display("FAIL reset_cnt1[%0d] got %0d want 0", k, c1[k]); end
    end
    rst_n = 1; iv = 0;
    tick();
  endtask
  task automatic test_manual_route();
    do_reset();
    r0 = 1; r1 = 1; iv = 1; idat = 8'h11; isel = 0;
    #1;
    vecs++;
    if (rdy[0] !== 1'b1) begin errs++; $display("FAIL man_rdy got %b want 1", rdy[0]); end
    tick();
    vecs += 2;
    if (v0[0] !== 1'b1) begin errs++; $display("FAIL man_v0 got %b want 1", v0[0]); end
    if (d0[0] !== 8'h11) begin errs++; $display("FAIL man_d0 got %h want 11", d0[0]); end
    idat = 8'h22; isel = 1;
    tick();
    vecs += 4;
    if (v1[0] !== 1'b1) begin errs++; $display("FAIL man_v1 got %b want 1", v1[0]); end
    if (d1[0] !== 8'h22) begin errs++; $display("FAIL man_d1 got %h want 22", d1[0]); end
    if (c0[0] !== 8'd1) begin errs++; $display("FAIL man_cnt0 got %0d want 1", c0[0]); end
    if (c1[0] !== 8'd1) begin errs++; $display("FAIL man_cnt1 got %0d want 1", c1[0]); end
    iv = 0;
    tick();
  endtask
  task automatic test_backpressure();
    do_reset();
    r0 = 0; r1 = 1; iv = 1; idat = 8'h33; isel = 0;
    tick();
    idat = 8'h44;
    #1;
    vecs++;
    if (rdy[0] !== 1'b0) begin errs++; $display("FAIL bp_rdy_stall got %b want 0", rdy[0]); end
    tick();
    vecs += 2;
    if (v0[0] !== 1'b1) begin errs++; $display("FAIL bp_v0_hold got %b want 1", v0[0]); end
    if (d0[0] !== 8'h33) begin errs++; $display("FAIL bp_d0_hold got %h want 33", d0[0]); end
    idat = 8'h55; isel = 1;
    #1;
    vecs++;
    if (rdy[0] !== 1'b1) begin errs++; $display("FAIL bp_rdy_other got %b want 1", rdy[0]); end
    tick();
    vecs += 2;
    if (d1[0] !== 8'h55) begin errs++; $display("FAIL bp_d1 got %h want 55", d1[0]); end
    if (d0[0] !== 8'h33) begin errs++; $display("FAIL bp_d0_kept got %h want 33", d0[0]); end
    idat = 8'h44; isel = 0; r0 = 1;
    #1;
    vecs++;
    if (rdy[0] !== 1'b1) begin errs++; $display("FAIL bp_rdy_release got %b want 1", rdy[0]); end
    tick();
    vecs += 4;
    if (v0[0] !== 1'b1) begin errs++; $display("FAIL bp_v0_refill got %b want 1", v0[0]); end
    if (d0[0] !== 8'h44) begin errs++; $display("FAIL bp_d0_refill got %h want 44", d0[0]); end
    if (v1[0] !== 1'b0) begin errs++; $display("FAIL bp_v1_drain got %b want 0", v1[0]); end
    if (d1[0] !== 8'h55) begin errs++; $display("FAIL bp_d1_after_drain got %h want 55", d1[0]); end
    iv = 0;
    tick();
  endtask
  task automatic test_auto_route();
    do_reset();
    r0 = 1; r1 = 1; iv = 1; isel = 1;
    for (int i = 1; i <= 6; i++) begin
      logic [7:0] e = 8'(i);
      idat = e;
      #1;
      vecs++;
      if (rdy[1] !== 1'b1) begin errs++; $display("FAIL auto_rdy beat %0d got %b want 1", i, rdy[1]); end
      tick();
      vecs += 2;
      if (i % 2 == 1) begin
        if (v0[1] !== 1'b1) begin errs++; $display("FAIL auto_v0 beat %0d got %b want 1", i, v0[1]); end
        if (d0[1] !== e) begin errs++; $display("FAIL auto_d0 beat %0d got %h want %h", i, d0[1], e); end
      end else begin
        if (v1[1] !== 1'b1) begin errs++; $display("FAIL auto_v1 beat %0d got %b want 1", i, v1[1]); end
        if (d1[1] !== e) begin errs++; $display("FAIL auto_d1 beat %0d got %h want %h", i, d1[1], e); end
      end
    end
    vecs += 3;
    if (sl[1] !== 1'b0) begin errs++; $display("FAIL auto_slot_end got %b want 0", sl[1]); end
    if (c0[1] !== 8'd3) begin errs++; $display("FAIL auto_cnt0 got %0d want 3", c0[1]); end
    if (c1[1] !== 8'd3) begin errs++; $display("FAIL auto_cnt1 got %0d want 3", c1[1]); end
    iv = 0;
    tick();
  endtask
  task automatic test_auto_stall();
    do_reset();
    r0 = 1; r1 = 0; iv = 1; isel = 0;
    for (int i = 1; i <= 3; i++) begin
      idat = 8'(i);
      tick();
    end
    idat = 8'h04;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs += 5;
      if (rdy[1] !== 1'b0) begin errs++; $display("FAIL stall_rdy cyc %0d got %b want 0", i, rdy[1]); end
      if (sl[1] !== 1'b1) begin errs++; $display("FAIL stall_slot cyc %0d got %b want 1", i, sl[1]); end
      if (d0[1] !== 8'h03) begin errs++; $display("FAIL stall_d0 cyc %0d got %h want 03", i, d0[1]); end
      if (d1[1] !== 8'h02) begin errs++; $display("FAIL stall_d1 cyc %0d got %h want 02", i, d1[1]); end
      if (v1[1] !== 1'b1) begin errs++; $display("FAIL stall_v1 cyc %0d got %b want 1", i, v1[1]); end
      tick();
    end
    vecs++;
    if (v0[1] !== 1'b0) begin errs++; $display("FAIL stall_no_reroute got %b want 0", v0[1]); end
    r1 = 1;
    #1;
    vecs++;
    if (rdy[1] !== 1'b1) begin errs++; $display("FAIL stall_release_rdy got %b want 1", rdy[1]); end
    tick();
    vecs += 2;
    if (d1[1] !== 8'h04) begin errs++; $display("FAIL stall_d1_resume got %h want 04", d1[1]); end
    if (sl[1] !== 1'b0) begin errs++; $display("FAIL stall_slot_resume got %b want 0", sl[1]); end
    idat = 8'h05;
    tick();
    vecs++;
    if (d0[1] !== 8'h05) begin errs++; $display("FAIL stall_d0_resume got %h want 05", d0[1]); end
    iv = 0;
    tick();
  endtask
  task automatic test_saturation();
    do_reset();
    r0 = 1; r1 = 1; iv = 1; isel = 0;
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] e = (i > 3) ? 8'd3 : 8'(i);
      idat = 8'(8'h80 + i);
      tick();
      vecs++;
      if (c0[2] !== e) begin errs++; $display("FAIL sat_cnt0 beat %0d got %0d want %0d", i, c0[2], e); end
    end
    r0 = 0; idat = 8'h86;
    tick();
    vecs += 2;
    if (v0[2] !== 1'b1) begin errs++; $display("FAIL sat_full got %b want 1", v0[2]); end
    if (c0[2] !== 8'd3) begin errs++; $display("FAIL sat_hold got %0d want 3", c0[2]); end
    rst_n = 0;
    tick();
    vecs += 3;
    if (v0[2] !== 1'b0) begin errs++; $display("FAIL sat_rst_v0 got %b want 0", v0[2]); end
    if (c0[2] !== 8'd0) begin errs++; $display("FAIL sat_rst_cnt0 got %0d want 0", c0[2]); end
    if (d0[2] !== 8'h00) begin errs++; $display("FAIL sat_rst_d0 got %h want 00", d0[2]); end
    rst_n = 1; iv = 0; r0 = 1;
    tick();
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      iv    = ($urandom_range(0, 3) != 0);
      isel  = 1'($urandom_range(0, 1));
      idat  = 8'($urandom);
      r0    = ($urandom_range(0, 2) != 0);
      r1    = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      #1;
      for (int k = 0; k < 3; k++) begin
        vecs++;
        if (rdy[k] !== exp_rdy(k)) begin errs++; $display("FAIL rnd_rdy[%0d] n=%0d got %b want %b", k, n, rdy[k], exp_rdy(k)); end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        vecs += 7;
        if (v0[k] !== mv[k][0]) begin errs++; $display("FAIL rnd_v0[%0d] n=%0d got %b want %b", k, n, v0[k], mv[k][0]); end
        if (v1[k] !== mv[k][1]) begin errs++; $display("FAIL rnd_v1[%0d] n=%0d got %b want %b", k, n, v1[k], mv[k][1]); end
        if (d0[k] !== md[k][0]) begin errs++; $display("FAIL rnd_d0[%0d] n=%0d got %h want %h", k, n, d0[k], md[k][0]); end
        if (d1[k] !== md[k][1]) begin errs++; $display("FAIL rnd_d1[%0d] n=%0d got %h want %h", k, n, d1[k], md[k][1]); end
        if (sl[k] !== ms[k]) begin errs++; $display("FAIL rnd_slot[%0d] n=%0d got %b want %b", k, n, sl[k], ms[k]); end
        if (c0[k] !== 8'(mc[k][0])) begin errs++; $display("FAIL rnd_cnt0[%0d] n=%0d got %0d want %0d", k, n, c0[k], mc[k][0]); end
        if (c1[k] !== 8'(mc[k][1])) begin errs++; $display("FAIL rnd_cnt1[%0d] n=%0d got %0d want %0d", k, n, c1[k], mc[k][1]); end
      end
    end
    rst_n = 1; iv = 0;
    tick();
  endtask
  initial begin
    rst_n = 0; iv = 0; isel = 0; idat = 0; r0 = 1; r1 = 1;
    test_reset();
    test_manual_route();
    test_backpressure();
    test_auto_route();
    test_auto_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
